// File: rtl/fft_mdc_pkg.sv
// fft_mdc_pkg: constants and complex sample type shared by the MDC FFT stages
package fft_mdc_pkg;
    localparam int DATA_W    = 9;
    localparam int FFT_N     = 32;
    localparam int FFT_LOG2N = $clog2(FFT_N);
    localparam int FFT_HALF  = FFT_N / 2;
    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;
endpackage

// File: rtl/half_frame_buffer.sv
// half_frame_buffer: D-entry register array, one write port, one asynchronous read port
//   clk          clock
//   we/waddr/wdata  write enable, address, data
//   raddr/rdata     combinational read
module half_frame_buffer #(
    parameter int W = 18,
    parameter int D = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [$clog2(D)-1:0] waddr,
    input  logic [W-1:0]         wdata,
    input  logic [$clog2(D)-1:0] raddr,
    output logic [W-1:0]         rdata
);
    logic [W-1:0] r_mem [D];
    always_ff @(posedge clk)
        if (we) r_mem[waddr] <= wdata;
    assign rdata = r_mem[raddr];
endmodule

// File: rtl/mdc_input_splitter.sv
// mdc_input_splitter: pairs x[n] with x[n+N/2] into the dual-path stream for MDC stage 1
//   clk, rst                   clock, synchronous active-high reset
//   in_valid, in_re, in_im     natural-order input samples
//   Up_out_*, Low_out_*        x[n] / x[n+N/2] pair, registered
//   out_valid                  pair present
//   out_frame_start/last       pair index 0 / N/2-1
//   out_count                  frame position of the pair (N/2..N-1)
module mdc_input_splitter
    import fft_mdc_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int N     = FFT_N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic signed [WIDTH-1:0] Up_out_re,
    output logic signed [WIDTH-1:0] Up_out_im,
    output logic signed [WIDTH-1:0] Low_out_re,
    output logic signed [WIDTH-1:0] Low_out_im,
    output logic                    out_valid,
    output logic                    out_frame_start,
    output logic                    out_frame_last,
    output logic [$clog2(N)-1:0]    out_count
);
    localparam int L    = $clog2(N);
    localparam int HALF = N / 2;
    logic [L-1:0]       r_cnt;
    logic               w_pair;
    logic [2*WIDTH-1:0] w_rd;
    // counter MSB is the FILL/PAIR state; the low bits address the buffer in both phases
    assign w_pair = r_cnt[L-1];
    half_frame_buffer #(.W(2*WIDTH), .D(HALF)) u_buf (
        .clk   (clk),
        .we    (in_valid & ~w_pair),
        .waddr (r_cnt[L-2:0]),
        .wdata ({in_re, in_im}),
        .raddr (r_cnt[L-2:0]),
        .rdata (w_rd)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt           <= '0;
            Up_out_re       <= '0;
            Up_out_im       <= '0;
            Low_out_re      <= '0;
            Low_out_im      <= '0;
            out_valid       <= 1'b0;
            out_frame_start <= 1'b0;
            out_frame_last  <= 1'b0;
            out_count       <= '0;
        end else begin
            out_valid       <= in_valid & w_pair;
            out_frame_start <= in_valid & (r_cnt == L'(HALF));
            out_frame_last  <= in_valid & (r_cnt == L'(N - 1));
            if (in_valid) r_cnt <= r_cnt + 1'b1;
            if (in_valid && w_pair) begin
                Up_out_re  <= w_rd[2*WIDTH-1:WIDTH];
                Up_out_im  <= w_rd[WIDTH-1:0];
                Low_out_re <= in_re;
                Low_out_im <= in_im;
                out_count  <= r_cnt;
            end
        end
    end
endmodule

// File: tb/tb_mdc_input_splitter.sv
// tb_mdc_input_splitter: scoreboard bench for the MDC input splitter
module tb_mdc_input_splitter;
    typedef struct {
        logic signed [8:0] ur, ui, lr, li;
        logic [4:0]        cnt;
        logic              st, la;
        int                due;
    } exp_t;
    logic clk = 0, rst = 1, in_valid = 0;
    logic signed [8:0] in_re = 0, in_im = 0;
    logic signed [8:0] Up_out_re, Up_out_im, Low_out_re, Low_out_im;
    logic out_valid, out_frame_start, out_frame_last;
    logic [4:0] out_count;
    int checks = 0, errors = 0, cyc = 0, idx = 0;
    bit mon_en = 0;
    logic signed [8:0] mre [16], mim [16];
    exp_t sb [$];
    mdc_input_splitter #(.WIDTH(9), .N(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .Up_out_re(Up_out_re), .Up_out_im(Up_out_im),
        .Low_out_re(Low_out_re), .Low_out_im(Low_out_im),
        .out_valid(out_valid), .out_frame_start(out_frame_start),
        .out_frame_last(out_frame_last), .out_count(out_count)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            checks++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                if (out_valid !== 1'b1 || Up_out_re !== e.ur || Up_out_im !== e.ui ||
                    Low_out_re !== e.lr || Low_out_im !== e.li || out_count !== e.cnt ||
                    out_frame_start !== e.st || out_frame_last !== e.la) begin
                    errors++;
                    $display("FAIL pair cyc=%0d got v=%b up=(%0d,%0d) low=(%0d,%0d) cnt=%0d s=%b l=%b want up=(%0d,%0d) low=(%0d,%0d) cnt=%0d s=%b l=%b",
                        cyc, out_valid, Up_out_re, Up_out_im, Low_out_re, Low_out_im, out_count,
                        out_frame_start, out_frame_last, e.ur, e.ui, e.lr, e.li, e.cnt, e.st, e.la);
                end
            end else if (out_valid !== 1'b0 || out_frame_start !== 1'b0 || out_frame_last !== 1'b0) begin
                errors++;
                $display("FAIL idle cyc=%0d got v=%b s=%b l=%b want 0 0 0", cyc, out_valid, out_frame_start, out_frame_last);
            end
        end
    end
    task automatic drive(input logic v, input int re, input int im);
        exp_t e;
        in_valid = v;
        in_re = 9'(re);
        in_im = 9'(im);
        if (rst) idx = 0;
        else if (v) begin
            if (idx < 16) begin
                mre[idx] = in_re;
                mim[idx] = in_im;
            end else begin
                e.ur = mre[idx-16]; e.ui = mim[idx-16];
                e.lr = in_re; e.li = in_im;
                e.cnt = 5'(idx); e.st = (idx == 16); e.la = (idx == 31);
                e.due = cyc + 1;
                sb.push_back(e);
            end
            idx = (idx + 1) % 32;
        end
        @(posedge clk); #1;
    endtask
    task automatic ramp(input int off, input bit gaps, input int upto);
        for (int n = 0; n < upto; n++) begin
            if (gaps) while ($urandom_range(0, 9) < 4) drive(0, 0, 0);
            drive(1, off + n, -(off + n));
        end
    endtask
    task automatic test_reset;
        rst = 1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (out_valid !== 0 || out_frame_start !== 0 || out_frame_last !== 0) begin errors++; $display("FAIL reset_flags got %b%b%b want 000", out_valid, out_frame_start, out_frame_last); end
        if (Up_out_re !== 0 || Up_out_im !== 0) begin errors++; $display("FAIL reset_up got %0d,%0d want 0,0", Up_out_re, Up_out_im); end
        if (Low_out_re !== 0 || Low_out_im !== 0) begin errors++; $display("FAIL reset_low got %0d,%0d want 0,0", Low_out_re, Low_out_im); end
        if (out_count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", out_count); end
        rst = 0;
        mon_en = 1;
    endtask
    task automatic test_ramp;
        ramp(0, 0, 32);
        drive(0, 0, 0);
        checks += 3;
        if (Up_out_re !== 15 || Up_out_im !== -15) begin errors++; $display("FAIL hold_up got %0d,%0d want 15,-15", Up_out_re, Up_out_im); end
        if (Low_out_re !== 31 || Low_out_im !== -31) begin errors++; $display("FAIL hold_low got %0d,%0d want 31,-31", Low_out_re, Low_out_im); end
        if (out_count !== 31) begin errors++; $display("FAIL hold_count got %0d want 31", out_count); end
    endtask
    task automatic test_back_to_back;
        ramp(0, 0, 32);
        ramp(64, 0, 32);
    endtask
    task automatic test_gaps;
        ramp(0, 1, 32);
        ramp(100, 1, 32);
    endtask
    task automatic test_extremes;
        for (int n = 0; n < 32; n++) drive(1, n[0] ? 255 : -256, n[0] ? -256 : 255);
    endtask
    task automatic test_rst_mid;
        ramp(0, 0, 20);
        rst = 1;
        drive(0, 0, 0);
        checks += 3;
        if (out_valid !== 0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        if (Up_out_re !== 0 || Low_out_re !== 0 || Up_out_im !== 0 || Low_out_im !== 0) begin errors++; $display("FAIL midrst_data got %0d,%0d want 0,0", Up_out_re, Low_out_re); end
        if (out_count !== 0) begin errors++; $display("FAIL midrst_count got %0d want 0", out_count); end
        rst = 0;
        ramp(0, 0, 32);
    endtask
    task automatic test_rst_valid;
        ramp(40, 0, 7);
        rst = 1;
        repeat (3) drive(1, 99, -99);
        rst = 0;
        ramp(0, 0, 32);
    endtask
    initial begin
        @(posedge clk); #1;
        test_reset;
        test_ramp;
        test_back_to_back;
        test_gaps;
        test_extremes;
        test_rst_mid;
        test_rst_valid;
        for (int i = 0; i < 10 && sb.size() > 0; i++) drive(0, 0, 0);
        drive(0, 0, 0);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain got %0d pending want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
